// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled start/data/parity/stop recovery with 3-sample vote.
// Ports: clk, rst (async low), RX_IN, PAR_EN, PAR_TYP, Prescale -> P_DATA, data_valid, par_err, stp_err.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t state, state_d;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] presc_l;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] p_last;
    logic [PRESCALE_W-1:0] s0_pt;
    logic [PRESCALE_W-1:0] s2_pt;
    logic [PRESCALE_W-1:0] vote_pt;
    logic [BW-1:0]         bit_cnt;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic [2:0]            smp;
    logic                  vote;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_flag;
    logic                  start_det;
    logic                  bit_end;
    logic                  dv_d;
    logic                  pe_d;
    logic                  se_d;

    // Sample points around the bit centre, derived from the latched prescale
    assign half    = presc_l >> 1;
    assign p_last  = presc_l - PRESCALE_W'(1);
    assign s0_pt   = half - PRESCALE_W'(1);
    assign s2_pt   = half + PRESCALE_W'(1);
    assign vote_pt = half + PRESCALE_W'(2);

    assign vote = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    // DONE doubles as an idle cycle so back-to-back frames lose no clock
    assign start_det = ((state == IDLE) || (state == DONE)) && !RX_IN;
    assign bit_end   = (edge_cnt == p_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!RX_IN) state_d = START;
            end
            START: begin
                if ((edge_cnt == vote_pt) && vote) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == LAST_BIT)) begin
                    state_d = par_en_l ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // Flags are computed here so the registered outputs
                // become visible during the DONE cycle itself
                if (bit_end) begin
                    state_d = DONE;
                    pe_d    = par_flag;
                    se_d    = !vote;
                    dv_d    = !par_flag && vote;
                end
            end
            DONE: begin
                state_d = RX_IN ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt  <= '0;
            presc_l   <= '0;
            bit_cnt   <= '0;
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            smp       <= '0;
            shreg     <= '0;
            par_flag  <= 1'b0;
        end else begin
            // Start-detect cycle is edge 0, so counting resumes at 1
            if (start_det) begin
                edge_cnt  <= PRESCALE_W'(1);
                bit_cnt   <= '0;
                presc_l   <= Prescale;
                par_en_l  <= PAR_EN;
                par_typ_l <= PAR_TYP;
                par_flag  <= 1'b0;
            end else if ((state == IDLE) || (state == DONE)) begin
                edge_cnt <= '0;
            end else if (bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end

            if (edge_cnt == s0_pt) smp[0] <= RX_IN;
            if (edge_cnt == half)  smp[1] <= RX_IN;
            if (edge_cnt == s2_pt) smp[2] <= RX_IN;

            if ((state == DATA) && bit_end) begin
                shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end

            if ((state == PARITY) && bit_end) begin
                par_flag <= par_typ_l ? ((^shreg) == vote)
                                      : ((^shreg) != vote);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= dv_d;
            par_err    <= pe_d;
            stp_err    <= se_d;
            if (dv_d) P_DATA <= shreg;
        end
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- UART receive datapath and control.
- Samples the asynchronous serial line RX_IN at Prescale× the bit rate and recovers one frame at a time:
  - 1 start bit (low);
  - DATA_WIDTH data bits, LSB first;
  - an optional parity bit;
  - 1 stop bit (high).
- Presents the byte on P_DATA with a one-cycle data_valid pulse.
- Flags parity and stop errors.
- It is the receive counterpart of the transmit serializer and sits between the RX pad synchroniser and the system controller.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the Prescale input.

Ports:
- clk  input  1  receiver oversampling clock.
- rst  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line, already synchronised to clk; idle high.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Prescale  input  PRESCALE_W  clocks per bit; legal values are 8, 16 and 32, and any other value gives undefined results.
- P_DATA  output  DATA_WIDTH  last correctly received data word.
- data_valid  output  1  one-cycle pulse: P_DATA updated.
- par_err  output  1  one-cycle pulse: parity mismatch in frame.
- stp_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (asynchronous, rst low):
  - P_DATA = 0; data_valid, par_err and stp_err = 0.
  - FSM = IDLE; all counters and the shift register = 0.
  - Reset mid-frame discards the frame with no pulses.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE, start detection:
  - The first cycle RX_IN == 0 is edge 0 of the start bit; go to START.
  - PAR_EN, PAR_TYP and Prescale are latched in that same cycle.
  - Changes to these inputs mid-frame are ignored.
- Bit timing:
  - edge_cnt counts 0..P-1 (P = latched Prescale); every bit lasts exactly P clocks.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling (majority vote):
  - RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the 3 samples, valid from edge_cnt = P/2+2.
- START:
  - If the voted start bit is 1 (glitch): return to IDLE at edge_cnt = P/2+2, with no pulses.
  - Otherwise, at edge_cnt = P-1 go to DATA.
- DATA:
  - Each voted bit shifts into the MSB of an internal shift register (LSB first on the line).
  - After bit DATA_WIDTH-1 completes (edge_cnt = P-1): go to PARITY if PAR_EN, else STOP.
- PARITY:
  - The voted bit is compared with the XOR of the data bits.
  - Mismatch condition: XOR(data) != voted bit when PAR_TYP = 0 (even), or XOR(data) == voted bit when PAR_TYP = 1 (odd).
  - The result is held internally; at edge_cnt = P-1 go to STOP.
- STOP:
  - A voted bit of 0 records a stop error.
  - At edge_cnt = P-1 go to DONE.
- DONE (exactly 1 cycle):
  - par_err = recorded parity error; stp_err = recorded stop error.
  - If both are 0: data_valid = 1 and P_DATA = shift register, registered so it is visible in this same cycle.
  - If either error is set: data_valid = 0 and P_DATA holds its old value.
  - par_err and stp_err may both be 1.
  - RX_IN == 0 in DONE is treated as edge 0 of a new start bit (go to START, latch config); otherwise go to IDLE.
- Latency: with the start-detect cycle counted as clock 0, DONE occurs at clock (2 + DATA_WIDTH + PAR_EN) × P.
- Back-to-back frames with no idle gap are received without loss.
- Outputs are registered; there are no combinational paths from RX_IN to any output.

Test Plan:
- P=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity bit 0 -> data_valid high for exactly 1 cycle at clock 88; P_DATA=0xA5; par_err=stp_err=0.
- P=16, PAR_EN=1, PAR_TYP=1, 0x3C sent with parity bit 0 (wrong for odd) -> par_err pulse at clock 176; no data_valid; P_DATA keeps 0xA5.
- P=32, PAR_EN=0, 0x81 with stop bit driven low -> stp_err pulse at clock 320; no data_valid; RX_IN then held low -> new frame starts from DONE.
- P=16: RX_IN low for 4 clocks then high (start glitch) -> FSM returns to IDLE; no pulses; a following valid 0x55 frame is received correctly.
- P=8, PAR_EN=0: frames 0x01, 0xFE, 0x7F sent back-to-back with no gap -> three data_valid pulses exactly 80 clocks apart with those values in order.
- P=8, 0xA5 frame with rst pulsed low during data bit 3 -> outputs go to 0 immediately; no pulses; the next full frame 0x12 is received correctly.
